// File: rtl/job_dispatcher_if.sv
// Job-dispatch bus: upstream descriptor handshake, core operand/start/done, and status.
// The slave side is the dispatcher; the master side is the producer/core environment.
interface job_dispatcher_if #(
  parameter int N = 4
);
  localparam int W = $clog2(N*16+256);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic [7:0]   in_z;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [7:0]   z_out;
  logic         start;
  logic         core_done;
  logic         busy;
  logic [7:0]   jobs_done;

  modport master (
    output in_valid, in_x, in_y, in_z, core_done,
    input  in_ready, x_out, y_out, z_out, start, busy, jobs_done
  );

  modport slave (
    input  in_valid, in_x, in_y, in_z, core_done,
    output in_ready, x_out, y_out, z_out, start, busy, jobs_done
  );
endinterface

// File: rtl/job_dispatcher.sv
// Buffers (x, y, z) job descriptors in a small FIFO and issues them one at a time to the core,
// holding operands until the core reports done; also reports busy and a wrapping job count.
module job_dispatcher #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  job_dispatcher_if.slave bus
);
  localparam int W  = $clog2(N*16+256);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mem_x [DEPTH];
  logic [W-1:0]  mem_y [DEPTH];
  logic [7:0]    mem_z [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [7:0]    z_q, z_d;
  logic          start_q, start_d;
  logic [7:0]    jobs_q, jobs_d;
  logic          in_ready;
  logic          push;
  logic          pop;

  // Readiness depends only on the registered count, never on this cycle's pop.
  assign in_ready = (count_q < FULL);
  assign push     = bus.in_valid && in_ready;

  // Descriptor storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr_q] <= bus.in_x;
      mem_y[wr_ptr_q] <= bus.in_y;
      mem_z[wr_ptr_q] <= bus.in_z;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    start_d = 1'b0;
    jobs_d  = jobs_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          x_d     = mem_x[rd_ptr_q];
          y_d     = mem_y[rd_ptr_q];
          z_d     = mem_z[rd_ptr_q];
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.core_done) begin
          jobs_d  = jobs_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      start_q  <= 1'b0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      start_q  <= start_d;
      jobs_q   <= jobs_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.z_out     = z_q;
  assign bus.start     = start_q;
  assign bus.busy      = (state_q != IDLE) || (count_q != '0);
  assign bus.jobs_done = jobs_q;
endmodule

// File: tb/tb_job_dispatcher.sv
// Randomized bench for job_dispatcher: a queue-based job model predicts status each cycle,
// and a scoreboard checks that issued operands follow acceptance order.
module tb_job_dispatcher;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int W     = $clog2(N*16+256);

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [7:0]   z;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  job_dispatcher_if #(.N(N)) bif();
  job_dispatcher #(.N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Reference model: pending jobs, the job the core owns, and its phase.
  job_t       m_fifo[$];
  job_t       exp_q[$];
  job_t       m_out;
  job_t       in_j;
  int         m_phase;       // 0 free, 1 just launched, 2 core working
  logic       m_start;
  logic [7:0] m_jobs;
  int         m_total;
  bit         m_acc;
  bit         room;
  bit         inited = 1'b0;
  int         done_mode = 0; // 0 low, 1 high, 2 random
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_out   = '0;
      m_phase = 0;
      m_start = 1'b0;
      m_jobs  = 8'd0;
      m_total = 0;
      inited  = 1'b1;
    end else if (inited) begin
      room    = m_fifo.size() < DEPTH;
      in_j    = '{x: bif.in_x, y: bif.in_y, z: bif.in_z};
      m_start = 1'b0;
      if (m_phase == 0) begin
        if (m_fifo.size() != 0) begin
          m_out   = m_fifo.pop_front();
          m_start = 1'b1;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (bif.core_done) begin
        m_jobs  = m_jobs + 8'd1;
        m_total = m_total + 1;
        m_phase = 0;
      end
      if (bif.in_valid && room) begin
        m_fifo.push_back(in_j);
        exp_q.push_back(in_j);
        m_acc = 1'b1;
      end
    end
  end

  // Monitor: status against the model every cycle, operands against the scoreboard on start.
  always @(negedge clk) begin
    if (inited) begin
      check("in_ready", 32'(bif.in_ready), 32'(m_fifo.size() < DEPTH));
      check("busy", 32'(bif.busy), 32'((m_phase != 0) || (m_fifo.size() != 0)));
      check("start", 32'(bif.start), 32'(m_start));
      check("jobs_done", 32'(bif.jobs_done), 32'(m_jobs));
      check("x_hold", 32'(bif.x_out), 32'(m_out.x));
      check("y_hold", 32'(bif.y_out), 32'(m_out.y));
      check("z_hold", 32'(bif.z_out), 32'(m_out.z));
      if (bif.start === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("start_without_job", 32'(1), 32'(0));
        end else begin
          job_t e;
          e = exp_q.pop_front();
          check("issue_x", 32'(bif.x_out), 32'(e.x));
          check("issue_y", 32'(bif.y_out), 32'(e.y));
          check("issue_z", 32'(bif.z_out), 32'(e.z));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (done_mode)
        0:       bif.core_done = 1'b0;
        1:       bif.core_done = 1'b1;
        default: bif.core_done = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Present one job starting at a negedge and hold it until the model accepts it.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [7:0] z);
    int k;
    bif.in_valid = 1'b1;
    bif.in_x = x;
    bif.in_y = y;
    bif.in_z = z;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_acc && k < 400);
    if (!m_acc) check("send_timeout", 32'(0), 32'(1));
    bif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(m_phase == 0 && m_fifo.size() == 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check("drain_timeout", 32'(0), 32'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_x = '0;
    bif.in_y = '0;
    bif.in_z = '0;
    bif.core_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single job with a slow core.
    done_mode = 0;
    send(W'(64), W'(0), 8'd0);
    repeat (6) @(negedge clk);
    done_mode = 1;
    @(negedge clk);
    done_mode = 0;
    drain();

    // Burst of six with the core stalled: five accepted, one rejected.
    for (int i = 0; i < 6; i++) begin
      bif.in_valid = 1'b1;
      bif.in_x = W'($urandom);
      bif.in_y = W'($urandom);
      bif.in_z = 8'(i + 10);
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    done_mode = 2;
    drain();

    // Done held high through ISSUE; continuous push/pop with z = 1..8.
    done_mode = 1;
    for (int i = 1; i <= 8; i++) send(W'($urandom), W'($urandom), 8'(i));
    drain();

    // Reset while WAIT with jobs queued, then a stray done.
    done_mode = 0;
    for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 8'(i + 40));
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk);
    done_mode = 1;
    repeat (3) @(negedge clk);
    done_mode = 0;
    @(negedge clk);

    // Random traffic.
    done_mode = 2;
    for (int i = 0; i < 400; i++) begin
      bif.in_valid = 1'($urandom_range(0, 1));
      bif.in_x = W'($urandom);
      bif.in_y = W'($urandom);
      bif.in_z = 8'($urandom);
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    drain();

    // Counter wrap: 258 completions from a fresh reset.
    do_reset();
    done_mode = 1;
    for (int i = 0; i < 300 && m_total < 258; i++)
      send(W'($urandom), W'($urandom), 8'($urandom));
    drain();
    check("wrap_total", 32'(bif.jobs_done), 32'(m_total % 256));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
